// File: rtl/taxi_axis_frame_trunc.sv
// AXI-Stream frame truncator: forwards frames up to a beat limit, marks the cut beat bad and drops the remainder.
// Define TAXI_AXIS_FRAME_TRUNC_STATS_EN to add saturating frame and truncation counters.
module taxi_axis_frame_trunc #(
    parameter int unsigned       DATA_W               = 8,
    parameter int unsigned       USER_W               = 1,
    parameter int unsigned       LEN_W                = 16,
    parameter logic [USER_W-1:0] USER_BAD_FRAME_VALUE = USER_W'(1)
) (
    input  logic              clk,
    input  logic              rst,

    input  logic [DATA_W-1:0] s_axis_tdata_i,
    input  logic              s_axis_tvalid_i,
    output logic              s_axis_tready_o,
    input  logic              s_axis_tlast_i,
    input  logic [USER_W-1:0] s_axis_tuser_i,

    output logic [DATA_W-1:0] m_axis_tdata_o,
    output logic              m_axis_tvalid_o,
    input  logic              m_axis_tready_i,
    output logic              m_axis_tlast_o,
    output logic [USER_W-1:0] m_axis_tuser_o,

    input  logic [LEN_W-1:0]  cfg_max_len_i,
    output logic              status_trunc_o,
    output logic [LEN_W-1:0]  status_frame_len_o,
    output logic              status_frame_done_o
`ifdef TAXI_AXIS_FRAME_TRUNC_STATS_EN
    ,
    output logic [31:0]       status_frame_cnt_o,
    output logic [31:0]       status_trunc_cnt_o
`endif
);

    localparam logic [LEN_W-1:0] CNT_MAX = {LEN_W{1'b1}};

    typedef enum logic {PASS, DROP} state_t;

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [LEN_W-1:0]   lim_q, lim_d;
    logic [DATA_W-1:0]  tdata_q, tdata_d;
    logic               tvalid_q, tvalid_d;
    logic               tlast_q, tlast_d;
    logic [USER_W-1:0]  tuser_q, tuser_d;
    logic               trunc_q, trunc_d;
    logic               done_q, done_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               s_ready;
    logic               accept;
    logic               cut;
    logic [LEN_W-1:0]   lim_cur;
    logic [LEN_W-1:0]   beat_num;
`ifdef TAXI_AXIS_FRAME_TRUNC_STATS_EN
    logic [31:0]        frame_cnt_q, frame_cnt_d;
    logic [31:0]        trunc_cnt_q, trunc_cnt_d;
`endif

    // Next-state, output register load and status generation.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        lim_d    = lim_q;
        tdata_d  = tdata_q;
        tvalid_d = tvalid_q && !m_axis_tready_i;
        tlast_d  = tlast_q;
        tuser_d  = tuser_q;
        trunc_d  = 1'b0;
        done_d   = 1'b0;
        len_d    = len_q;
        cut      = 1'b0;
`ifdef TAXI_AXIS_FRAME_TRUNC_STATS_EN
        frame_cnt_d = frame_cnt_q;
        trunc_cnt_d = trunc_cnt_q;
`endif
        // A cleared counter marks the first beat of a frame, where the limit is sampled.
        lim_cur  = (cnt_q == '0) ? cfg_max_len_i : lim_q;
        beat_num = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + LEN_W'(1);
        s_ready  = !rst && ((state_q == DROP) || !tvalid_q || m_axis_tready_i);
        accept   = s_axis_tvalid_i && s_ready;

        unique case (state_q)
            PASS: begin
                if (accept) begin
                    cut      = (lim_cur != '0) && (beat_num == lim_cur) && !s_axis_tlast_i;
                    lim_d    = lim_cur;
                    tvalid_d = 1'b1;
                    tdata_d  = s_axis_tdata_i;
                    tlast_d  = s_axis_tlast_i || cut;
                    tuser_d  = cut ? USER_BAD_FRAME_VALUE : s_axis_tuser_i;
                    cnt_d    = (s_axis_tlast_i || cut) ? '0 : beat_num;
                    if (s_axis_tlast_i || cut) begin
                        done_d = 1'b1;
                        len_d  = beat_num;
`ifdef TAXI_AXIS_FRAME_TRUNC_STATS_EN
                        if (frame_cnt_q != 32'hFFFF_FFFF) frame_cnt_d = frame_cnt_q + 32'd1;
`endif
                    end
                    if (cut) begin
                        trunc_d = 1'b1;
                        state_d = DROP;
`ifdef TAXI_AXIS_FRAME_TRUNC_STATS_EN
                        if (trunc_cnt_q != 32'hFFFF_FFFF) trunc_cnt_d = trunc_cnt_q + 32'd1;
`endif
                    end
                end
            end
            DROP: begin
                if (accept && s_axis_tlast_i) state_d = PASS;
            end
            default: state_d = PASS;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= PASS;
            cnt_q    <= '0;
            lim_q    <= '0;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            tuser_q  <= '0;
            trunc_q  <= 1'b0;
            done_q   <= 1'b0;
            len_q    <= '0;
`ifdef TAXI_AXIS_FRAME_TRUNC_STATS_EN
            frame_cnt_q <= '0;
            trunc_cnt_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            lim_q    <= lim_d;
            tdata_q  <= tdata_d;
            tvalid_q <= tvalid_d;
            tlast_q  <= tlast_d;
            tuser_q  <= tuser_d;
            trunc_q  <= trunc_d;
            done_q   <= done_d;
            len_q    <= len_d;
`ifdef TAXI_AXIS_FRAME_TRUNC_STATS_EN
            frame_cnt_q <= frame_cnt_d;
            trunc_cnt_q <= trunc_cnt_d;
`endif
        end
    end

    assign s_axis_tready_o     = s_ready;
    assign m_axis_tdata_o      = tdata_q;
    assign m_axis_tvalid_o     = tvalid_q;
    assign m_axis_tlast_o      = tlast_q;
    assign m_axis_tuser_o      = tuser_q;
    assign status_trunc_o      = trunc_q;
    assign status_frame_len_o  = len_q;
    assign status_frame_done_o = done_q;
`ifdef TAXI_AXIS_FRAME_TRUNC_STATS_EN
    assign status_frame_cnt_o  = frame_cnt_q;
    assign status_trunc_cnt_o  = trunc_cnt_q;
`endif

endmodule

// File: tb/tb_taxi_axis_frame_trunc.sv
// Randomised bench for taxi_axis_frame_trunc with a frame-level reference model and directed scenarios.
module tb_taxi_axis_frame_trunc;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned USER_W = 1;
    localparam int unsigned LEN_W  = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [DATA_W-1:0] s_tdata = '0;
    logic              s_tvalid = 1'b0;
    logic              s_tready;
    logic              s_tlast = 1'b0;
    logic [USER_W-1:0] s_tuser = '0;
    logic [DATA_W-1:0] m_tdata;
    logic              m_tvalid;
    logic              m_tready = 1'b0;
    logic              m_tlast;
    logic [USER_W-1:0] m_tuser;
    logic [LEN_W-1:0]  cfg = '0;
    logic              st_trunc;
    logic [LEN_W-1:0]  st_len;
    logic              st_done;
`ifdef TAXI_AXIS_FRAME_TRUNC_STATS_EN
    logic [31:0]       st_frame_cnt;
    logic [31:0]       st_trunc_cnt;
`endif

    always #5 clk = ~clk;

    taxi_axis_frame_trunc dut (
        .clk(clk), .rst(rst),
        .s_axis_tdata_i(s_tdata), .s_axis_tvalid_i(s_tvalid), .s_axis_tready_o(s_tready),
        .s_axis_tlast_i(s_tlast), .s_axis_tuser_i(s_tuser),
        .m_axis_tdata_o(m_tdata), .m_axis_tvalid_o(m_tvalid), .m_axis_tready_i(m_tready),
        .m_axis_tlast_o(m_tlast), .m_axis_tuser_o(m_tuser),
        .cfg_max_len_i(cfg), .status_trunc_o(st_trunc),
        .status_frame_len_o(st_len), .status_frame_done_o(st_done)
`ifdef TAXI_AXIS_FRAME_TRUNC_STATS_EN
        , .status_frame_cnt_o(st_frame_cnt), .status_trunc_cnt_o(st_trunc_cnt)
`endif
    );

    typedef struct packed {logic [7:0] data; logic last; logic user; logic [15:0] cfg;} stim_t;
    typedef struct packed {logic [7:0] data; logic last; logic user;} beat_t;

    stim_t stim_q[$];
    beat_t exp_q[$];
    beat_t obs_q[$];

    int checks = 0;
    int fails  = 0;

    // Frame-level model state
    int unsigned m_idx = 0;
    logic [15:0] m_lim = '0;
    bit          m_drop = 0;
    logic [15:0] m_len = '0;
    bit          exp_trunc = 0, exp_done = 0, exp_load = 0, hold_prev = 0, acc_pend = 0;
    beat_t       exp_load_beat, prev_beat;
    int          n_out = 0, n_trunc = 0, n_done = 0;
    int          valid_pct = 100, ready_pct = 100;
    bit          toggle = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        exp_q.delete();
        m_idx = 0; m_lim = '0; m_drop = 0; m_len = '0;
        exp_trunc = 0; exp_done = 0; exp_load = 0; hold_prev = 0; acc_pend = 0;
    endtask

    // Applies the frame rules to one accepted input beat.
    task automatic model_accept(input stim_t s);
        beat_t b;
        if (m_drop) begin
            if (s.last) m_drop = 0;
            return;
        end
        if (m_idx == 0) m_lim = s.cfg;
        if (m_idx < 65535) m_idx++;
        b.data = s.data; b.last = s.last; b.user = s.user;
        if (m_lim != 0 && m_idx == 32'(m_lim) && !s.last) begin
            b.last = 1'b1; b.user = 1'b1; m_drop = 1; exp_trunc = 1;
        end
        if (b.last) begin
            exp_done = 1; m_len = 16'(m_idx); m_idx = 0;
        end
        exp_q.push_back(b);
        exp_load = 1; exp_load_beat = b;
    endtask

    task automatic step();
        beat_t cur, b;
        @(negedge clk);
        if (!rst) begin
            chk("status_trunc", 32'(st_trunc), 32'(exp_trunc));
            chk("status_frame_done", 32'(st_done), 32'(exp_done));
            chk("status_frame_len", 32'(st_len), 32'(m_len));
            cur = {m_tdata, m_tlast, m_tuser};
            if (exp_load) begin
                chk("latency_valid", 32'(m_tvalid), 1);
                chk("latency_beat", 32'(cur), 32'(exp_load_beat));
            end else if (hold_prev) begin
                chk("hold_valid", 32'(m_tvalid), 1);
                chk("hold_beat", 32'(cur), 32'(prev_beat));
            end
            if (st_trunc) n_trunc++;
            if (st_done) n_done++;
        end
        if (acc_pend) s_tvalid = 1'b0;
        acc_pend = 0;
        if (rst) begin
            s_tvalid = 1'b0;
        end else if (stim_q.size() != 0) begin
            if (!s_tvalid) s_tvalid = ($urandom_range(99) < valid_pct);
            s_tdata = stim_q[0].data; s_tlast = stim_q[0].last;
            s_tuser = stim_q[0].user; cfg = stim_q[0].cfg;
        end else begin
            s_tvalid = 1'b0;
        end
        if (toggle) m_tready = !m_tready;
        else m_tready = ($urandom_range(99) < ready_pct);
        #1;
        exp_trunc = 0; exp_done = 0; exp_load = 0;
        if (rst) begin
            chk("tready_in_reset", 32'(s_tready), 0);
            hold_prev = 0;
        end else begin
            chk("s_tready", 32'(s_tready), 32'(m_drop || !m_tvalid || m_tready));
            hold_prev = m_tvalid && !m_tready;
            prev_beat = {m_tdata, m_tlast, m_tuser};
            if (m_tvalid && m_tready) begin
                cur = {m_tdata, m_tlast, m_tuser};
                obs_q.push_back(cur);
                n_out++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_out_beat", 32'(exp_q.size()), 1);
                end else begin
                    b = exp_q.pop_front();
                    chk("out_beat", 32'(cur), 32'(b));
                end
            end
            if (s_tvalid && s_tready) begin
                model_accept(stim_q.pop_front());
                acc_pend = 1;
            end
        end
    endtask

    task automatic do_reset(input int cyc);
        rst = 1'b1; s_tvalid = 1'b0;
        repeat (cyc) step();
        model_clear();
        chk("rst_tvalid", 32'(m_tvalid), 0);
        chk("rst_tdata", 32'(m_tdata), 0);
        chk("rst_tlast", 32'(m_tlast), 0);
        chk("rst_tuser", 32'(m_tuser), 0);
        chk("rst_trunc", 32'(st_trunc), 0);
        chk("rst_done", 32'(st_done), 0);
        chk("rst_len", 32'(st_len), 0);
        rst = 1'b0;
    endtask

    task automatic add_frame(input int len, input logic [15:0] lim, input logic [7:0] base, input bit rnd);
        stim_t s;
        for (int i = 0; i < len; i++) begin
            s.data = rnd ? 8'($urandom) : 8'(base + 8'(i));
            s.last = (i == len - 1);
            s.user = rnd ? 1'($urandom_range(1)) : 1'b0;
            s.cfg  = lim;
            stim_q.push_back(s);
        end
    endtask

    task automatic phase_start();
        n_out = 0; n_trunc = 0; n_done = 0; obs_q.delete();
    endtask

    task automatic run_until_idle();
        int n = 0;
        while ((stim_q.size() != 0 || exp_q.size() != 0 || m_tvalid) && n < 20000) begin
            step();
            n++;
        end
        chk("drain_within_budget", 32'(n < 20000), 1);
        repeat (3) step();
    endtask

    initial begin
        do_reset(3);

        // 5-beat frame under limit 8
        phase_start();
        add_frame(5, 16'd8, 8'h01, 0);
        run_until_idle();
        chk("short_n_out", 32'(n_out), 5);
        chk("short_n_trunc", 32'(n_trunc), 0);
        chk("short_len", 32'(st_len), 5);
        chk("short_beat0", 32'(obs_q[0]), 32'({8'h01, 1'b0, 1'b0}));
        chk("short_beat4", 32'(obs_q[4]), 32'({8'h05, 1'b1, 1'b0}));

        // 10-beat frame cut to 4, then an intact 3-beat frame
        phase_start();
        valid_pct = 70; ready_pct = 60;
        add_frame(10, 16'd4, 8'h10, 0);
        add_frame(3, 16'd4, 8'h40, 0);
        run_until_idle();
        chk("cut_n_out", 32'(n_out), 7);
        chk("cut_n_trunc", 32'(n_trunc), 1);
        chk("cut_n_done", 32'(n_done), 2);
        chk("cut_beat3", 32'(obs_q[3]), 32'({8'h13, 1'b1, 1'b1}));
        chk("cut_next_first", 32'(obs_q[4]), 32'({8'h40, 1'b0, 1'b0}));
        chk("cut_len", 32'(st_len), 3);

        // Exactly-limit frame, then another frame to confirm PASS state
        phase_start();
        add_frame(4, 16'd4, 8'h20, 0);
        add_frame(2, 16'd4, 8'h30, 0);
        run_until_idle();
        chk("exact_n_out", 32'(n_out), 6);
        chk("exact_n_trunc", 32'(n_trunc), 0);
        chk("exact_beat3", 32'(obs_q[3]), 32'({8'h23, 1'b1, 1'b0}));

        // Single-beat frame at limit 1, then 2-beat frame at limit 1
        phase_start();
        add_frame(1, 16'd1, 8'h55, 0);
        add_frame(2, 16'd1, 8'h60, 0);
        run_until_idle();
        chk("single_n_out", 32'(n_out), 2);
        chk("single_n_trunc", 32'(n_trunc), 1);
        chk("single_beat", 32'(obs_q[0]), 32'({8'h55, 1'b1, 1'b0}));

        // Unlimited 300-beat frame with toggling backpressure
        phase_start();
        valid_pct = 100; toggle = 1;
        add_frame(300, 16'd0, 8'h00, 0);
        run_until_idle();
        toggle = 0;
        chk("long_n_out", 32'(n_out), 300);
        chk("long_len", 32'(st_len), 300);
        chk("long_n_trunc", 32'(n_trunc), 0);

        // Limit lowered mid-frame takes effect on the next frame only
        phase_start();
        ready_pct = 80;
        add_frame(6, 16'd8, 8'h70, 0);
        for (int i = 2; i < 6; i++) stim_q[i].cfg = 16'd2;
        add_frame(6, 16'd2, 8'h80, 0);
        run_until_idle();
        chk("relimit_n_out", 32'(n_out), 8);
        chk("relimit_n_trunc", 32'(n_trunc), 1);
        chk("relimit_len", 32'(st_len), 2);

        // Reset with a beat stalled in the output register
        phase_start();
        ready_pct = 0; valid_pct = 100;
        add_frame(6, 16'd0, 8'h90, 0);
        repeat (4) step();
        chk("stall_held_valid", 32'(m_tvalid), 1);
        stim_q.delete();
        do_reset(1);
        phase_start();
        ready_pct = 100;
        add_frame(3, 16'd0, 8'hA0, 0);
        run_until_idle();
        chk("post_rst_n_out", 32'(n_out), 3);
        chk("post_rst_len", 32'(st_len), 3);

        // Random frames, limits, mid-frame limit changes and handshakes
        for (int f = 0; f < 60; f++) begin
            int len;
            logic [15:0] lim;
            len = int'($urandom_range(12, 1));
            lim = 16'($urandom_range(8));
            add_frame(len, lim, 8'h00, 1);
            for (int i = stim_q.size() - len + 1; i < stim_q.size(); i++)
                if ($urandom_range(3) == 0) stim_q[i].cfg = 16'($urandom_range(8));
        end
        valid_pct = 75; ready_pct = 65;
        run_until_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/taxi_axis_frame_trunc.md
TAXI_AXIS_FRAME_TRUNC -- requirements
Module: taxi_axis_frame_trunc

Interface
REQ-001 Parameter DATA_W, default 8, tdata width; SHALL be 8, one byte per beat, tkeep unused.
REQ-002 Parameter USER_W, default 1, tuser width.
REQ-003 Parameter LEN_W, default 16, width of length config and status.
REQ-004 Parameter USER_BAD_FRAME_VALUE, default 1'b1, tuser value forced on the last beat of a truncated frame.
REQ-005 clk  input  1  sole clock; all logic on rising edge.
REQ-006 rst  input  1  reset; synchronous, active-high.
REQ-007 s_axis  sink  taxi_axis_if  input stream (tdata, tvalid, tready, tlast, tuser); typically fed by an async FIFO master port.
REQ-008 m_axis  source  taxi_axis_if  output stream, same signal set.
REQ-009 cfg_max_len  input  LEN_W  maximum frame length in beats; 0 = unlimited.
REQ-010 status_trunc  output  1  one-cycle pulse when a frame is truncated.
REQ-011 status_frame_len  output  LEN_W  beat count of the last completed output frame, saturating at all-ones.
REQ-012 status_frame_done  output  1  one-cycle pulse when status_frame_len updates.

Function
REQ-013 Output SHALL be a single register stage: latency 1 cycle from s_axis accept to m_axis tvalid.
REQ-014 s_axis.tready SHALL be (!m_axis.tvalid || m_axis.tready) in PASS; constant 1 in DROP.
REQ-015 m_axis.tvalid, once asserted, SHALL hold with stable tdata/tlast/tuser until m_axis.tready is high.
REQ-016 FSM states: PASS (forward beats) and DROP (discard beats); reset state PASS.
REQ-017 cfg_max_len SHALL be latched at the first beat of each frame; mid-frame changes have no effect until the next frame.
REQ-018 Beat counter (LEN_W bits) SHALL increment per accepted beat in PASS, saturate at all-ones, and clear after a tlast beat is output.
REQ-019 In PASS, when the accepted beat is beat number N = latched limit (N nonzero) and input tlast = 0: output beat SHALL carry tlast = 1 and tuser = USER_BAD_FRAME_VALUE, status_trunc pulses, state -> DROP.
REQ-020 When beat number N carries input tlast = 1: frame passes unmodified, no truncation, state stays PASS.
REQ-021 In DROP, beats SHALL be accepted and discarded with no output; on accepted tlast state -> PASS.
REQ-022 Limit 0 or a frame shorter than the limit SHALL pass bit-exact, including original tuser.
REQ-023 status_frame_done SHALL pulse, and status_frame_len update, in the cycle a tlast beat is loaded into the output register.
REQ-024 Single-beat frames (tlast on first beat) SHALL pass with length 1, including limit 1.
REQ-025 A beat loaded in the same cycle the output register drains SHALL be accepted with no bubble (full throughput).

Reset
REQ-026 On rst: m_axis.tvalid = 0, tlast = 0, tuser = 0, tdata = 0, state = PASS, counter = 0, status_trunc = 0, status_frame_done = 0, status_frame_len = 0.
REQ-027 Reset mid-frame SHALL drop any held output beat; the next accepted beat after reset starts a new frame.
REQ-028 During rst, s_axis.tready SHALL be 0.

Configuration
REQ-029 Macro TAXI_AXIS_FRAME_TRUNC_STATS_EN defined: adds outputs status_frame_cnt (32 bits) and status_trunc_cnt (32 bits), counting output frames and truncations, saturating, cleared by rst.
REQ-030 Macro undefined: these ports and counters SHALL be absent; all other behaviour identical.

Verification
REQ-031 Limit 8, 5-beat frame 0x01..0x05 -> identical 5 beats out, tuser 0, status_frame_len = 5, no status_trunc.
REQ-032 Limit 4, 10-beat frame -> 4 beats out, 4th has tlast = 1 and tuser = 1; status_trunc pulse; beats 5-10 consumed with no output; next frame passes intact.
REQ-033 Limit 4, exactly 4-beat frame -> passed unmodified, no truncation, state remains PASS.
REQ-034 Limit 0, 300-beat frame with m_axis.tready toggling every cycle -> all 300 beats out in order, data held stable while stalled, status_frame_len = 300.
REQ-035 Limit changed 8 -> 2 at beat 3 of a 6-beat frame -> frame passes whole; following 6-beat frame truncated to 2.
REQ-036 rst asserted with a beat held in the output register mid-frame -> m_axis.tvalid = 0 next cycle; subsequent 3-beat frame out with length 3.
